uart_program_loader: RTL
========================

Name: uart_program_loader

Overview:
- Boot-time loader that sits upstream of the execute stage and the instruction memory.
- While the core is in LOAD mode (mode==1), it waits for the 0xAA handshake byte to be transmitted. It then takes raw bytes from the UART RX path, assembles them into 32-bit instruction words and writes them sequentially into instruction memory.
- It raises a done flag that the mode controller uses to switch the core to EXEC (mode==2).

Parameters:
- IMEM_ADDR_W, 14, instruction-memory word-address width; capacity is 2**IMEM_ADDR_W words.
- LOAD_MODE, 3'd1, value of mode that enables the loader.

Ports:
- clk  input  1  system clock
- rstn  input  1  reset, asynchronous, active-low
- mode  input  3  core mode; loader active only when mode==LOAD_MODE
- aa_sent  input  1  level; 0xAA handshake byte has been transmitted
- rx_data  input  8  received byte from uart_rx
- rx_ready  input  1  one-cycle strobe; rx_data valid
- imem_we  output  1  instruction-memory write enable, one-cycle pulse
- imem_addr  output  IMEM_ADDR_W  word address of the write
- imem_wdata  output  32  instruction word
- words_loaded  output  IMEM_ADDR_W+1  count of words written in the current load
- load_done  output  1  level; load completed successfully
- load_err  output  1  level; load aborted with an error

Behaviour:
- Reset: asynchronous on rstn low. All outputs are 0 and the state is IDLE.
- States: IDLE, WAIT_AA, LEN, DATA, CSUM (macro only), DONE, ERR.
- IDLE:
  - mode==LOAD_MODE -> WAIT_AA.
  - Byte counter, word counter and shift register are cleared on entry.
- WAIT_AA:
  - aa_sent==1 -> LEN.
  - rx_ready strobes in this state are ignored.
- LEN:
  - Collect 4 bytes, big-endian (first byte is bits 31:24), forming word count N.
  - N==0 -> DONE on the cycle after the 4th byte.
  - N > 2**IMEM_ADDR_W -> ERR.
  - Otherwise -> DATA.
- DATA:
  - Collect bytes big-endian into a 32-bit shift register.
  - On the 4th byte of a word: the next cycle drives imem_we=1, imem_wdata=assembled word, imem_addr=word index starting at 0. words_loaded increments in the same cycle.
  - Write latency is one cycle from the rx_ready carrying the final byte to the imem_we pulse.
  - After word N-1 is written -> DONE (or CSUM when the macro is defined).
- DONE: load_done=1, held until mode != LOAD_MODE, then -> IDLE with load_done cleared.
- ERR: load_err=1 and no further writes. Held until mode != LOAD_MODE, then -> IDLE with load_err cleared.
- mode leaves LOAD_MODE in WAIT_AA, LEN or DATA:
  - Abort to IDLE on the next edge.
  - Any partial word is discarded and no imem_we is issued for it.
  - A write already scheduled for that edge still completes.
  - load_done and load_err stay 0.
- rx_ready arriving in the same cycle as an imem_we pulse is accepted normally; the byte counter and the write path are independent.
- Address arithmetic: imem_addr is the low IMEM_ADDR_W bits of the word index. N==2**IMEM_ADDR_W fills memory exactly, with the last address = all ones and no wrap.
- imem_addr and imem_wdata hold their last written value when imem_we==0.
- rx_ready strobes in DONE, ERR or IDLE are ignored.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word, state CSUM accepts one byte.
  - That byte must equal the XOR of all 4N data bytes; the length bytes are excluded.
  - Match -> DONE. Mismatch -> ERR; words already written stay in memory.
  - For N==0 the expected checksum is 0x00 and LEN goes to CSUM.
- Not defined: no CSUM state; the last write goes straight to DONE and no trailing byte is consumed.

Test Plan:
- Basic load:
  - mode=1; aa_sent rises; send 00 00 00 02, DE AD BE EF, 12 34 56 78.
  - Expect imem_we at addr 0 with 0xDEADBEEF, then at addr 1 with 0x12345678; words_loaded=2; load_done=1.
  - mode=2 -> load_done=0.
- Zero length: send 00 00 00 00 -> load_done=1, no imem_we pulse.
- Oversize: IMEM_ADDR_W=4; send 00 00 00 11 (N=17) -> load_err=1, no writes, subsequent bytes ignored.
- Abort mid-word:
  - N=1; send 3 bytes, then mode=0 -> IDLE, no imem_we.
  - Re-enter mode=1 and do a fresh load of N=1 AABBCCDD -> addr 0 = 0xAABBCCDD.
- Handshake gating and async reset:
  - Bytes sent before aa_sent are ignored.
  - rstn low mid-DATA -> all outputs 0 immediately, without waiting for a clock.
- With LOADER_CHECKSUM_EN:
  - N=1, 01 02 03 04, checksum 04 -> load_done.
  - Same data with checksum 05 -> load_err, addr 0 = 0x01020304.

Source files
------------

// File: rtl/uart_program_loader.sv
// Boot loader: assembles UART bytes into instruction words and writes IMEM.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module uart_program_loader #(
    parameter int         IMEM_ADDR_W = 14,
    parameter logic [2:0] LOAD_MODE   = 3'd1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [2:0]             mode,
    input  logic                   aa_sent,
    input  logic [7:0]             rx_data,
    input  logic                   rx_ready,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [31:0]            imem_wdata,
    output logic [IMEM_ADDR_W:0]   words_loaded,
    output logic                   load_done,
    output logic                   load_err
);

    localparam int          CNT_W = IMEM_ADDR_W + 1;
    localparam logic [32:0] CAP   = 33'd1 << IMEM_ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_AA,
        S_LEN,
        S_DATA,
        S_DONE,
        S_ERR
`ifdef LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t state, state_nxt;

    logic [1:0]       byte_cnt;
    logic [31:0]      shreg;
    logic [CNT_W-1:0] len_n;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    logic        active;
    logic        take;
    logic        last_byte;
    logic        last_word;
    logic [31:0] asm_word;
    logic        len_zero;
    logic        len_big;

    assign active    = (mode == LOAD_MODE);
    assign take      = active && rx_ready;
    assign last_byte = (byte_cnt == 2'd3);
    assign asm_word  = {shreg[23:0], rx_data};
    assign len_zero  = (asm_word == 32'd0);
    assign len_big   = ({1'b0, asm_word} > CAP);
    assign last_word = ((words_loaded + CNT_W'(1)) == len_n);

    assign load_done = (state == S_DONE);
    assign load_err  = (state == S_ERR);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (active) state_nxt = S_WAIT_AA;
            end
            S_WAIT_AA: begin
                if (!active)      state_nxt = S_IDLE;
                else if (aa_sent) state_nxt = S_LEN;
            end
            S_LEN: begin
                if (!active) begin
                    state_nxt = S_IDLE;
                end else if (rx_ready && last_byte) begin
                    if (len_zero) begin
`ifdef LOADER_CHECKSUM_EN
                        state_nxt = S_CSUM;
`else
                        state_nxt = S_DONE;
`endif
                    end else if (len_big) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (!active) begin
                    state_nxt = S_IDLE;
                end else if (rx_ready && last_byte && last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nxt = S_CSUM;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (!active)       state_nxt = S_IDLE;
                else if (rx_ready) state_nxt = (rx_data == csum) ? S_DONE : S_ERR;
            end
`endif
            S_DONE, S_ERR: begin
                if (!active) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Write path is registered: imem_we lands one cycle after the 4th byte.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
            byte_cnt     <= '0;
            shreg        <= '0;
            len_n        <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            if (state == S_IDLE) begin
                words_loaded <= '0;
                byte_cnt     <= '0;
                shreg        <= '0;
                len_n        <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum         <= '0;
`endif
            end else if (take && (state == S_LEN || state == S_DATA)) begin
                byte_cnt <= byte_cnt + 2'd1;
                shreg    <= asm_word;
                if (state == S_LEN && last_byte) begin
                    len_n <= asm_word[CNT_W-1:0];
                end
                if (state == S_DATA) begin
`ifdef LOADER_CHECKSUM_EN
                    csum <= csum ^ rx_data;
`endif
                    if (last_byte) begin
                        imem_we      <= 1'b1;
                        imem_addr    <= words_loaded[IMEM_ADDR_W-1:0];
                        imem_wdata   <= asm_word;
                        words_loaded <= words_loaded + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule
